// File: rtl/regfile_wb_ctrl.sv
// Single write-port controller for the register file: round-robin arbitration of
// ALU and load writebacks, plus a pending-load scoreboard for RAW hazard detection.
module regfile_wb_ctrl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [REGW-1:0] alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [REGW-1:0] ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_issue,
  input  logic [REGW-1:0] ld_issue_rd,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            rf_we,
  output logic [REGW-1:0] rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic            err_unexpected
);

  typedef enum logic {GRANT_ALU, GRANT_LOAD} grant_t;

  grant_t          last_grant;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_next;
  logic            alu_xfer;
  logic            ld_xfer;

  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (!reset) begin
      if (alu_valid && ld_valid) begin
        alu_ready = (last_grant == GRANT_LOAD);
        ld_ready  = (last_grant == GRANT_ALU);
      end else begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid;
      end
    end
  end

  assign alu_xfer = alu_valid && alu_ready;
  assign ld_xfer  = ld_valid && ld_ready;

  // Clear before set so a load issued in the same cycle supersedes the retiring one.
  always_comb begin
    pending_next = pending;
    if (ld_xfer) pending_next[ld_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != '0)) pending_next[ld_issue_rd] = 1'b1;
  end

  assign rs1_busy = (rs1 != '0) && pending[rs1];
  assign rs2_busy = (rs2 != '0) && pending[rs2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we          <= 1'b0;
      rf_rd          <= '0;
      rf_wdata       <= '0;
      pending        <= '0;
      err_unexpected <= 1'b0;
      last_grant     <= GRANT_LOAD;
    end else begin
      pending <= pending_next;
      rf_we   <= 1'b0;
      if (alu_xfer) begin
        last_grant <= GRANT_ALU;
        if (alu_rd != '0) begin
          rf_we    <= 1'b1;
          rf_rd    <= alu_rd;
          rf_wdata <= alu_data;
        end
      end else if (ld_xfer) begin
        last_grant <= GRANT_LOAD;
        if (ld_rd != '0) begin
          rf_we    <= 1'b1;
          rf_rd    <= ld_rd;
          rf_wdata <= ld_data;
          if (!pending[ld_rd]) err_unexpected <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Scoreboard bench for regfile_wb_ctrl: directed scenarios then randomized traffic
// against a reference model of the arbitration and pending-load rules.
module tb_regfile_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0, ld_valid = 1'b0, ld_issue = 1'b0;
  logic [4:0]  alu_rd = '0, ld_rd = '0, ld_issue_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic        alu_ready, ld_ready, rs1_busy, rs2_busy, rf_we, err_unexpected;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  regfile_wb_ctrl #(.XLEN(32), .NREG(32), .REGW(5)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference state: set of registers with loads in flight, sticky error, who won last.
  bit          m_pend [32];
  bit          m_err = 0;
  bit          m_alu_won_last = 0;
  bit          m_alu_x, m_ld_x;
  logic [36:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every accepted non-x0 request must appear exactly once, in order, one cycle later.
  always @(negedge clk) begin
    if (!reset) begin
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we", 32'(rf_rd), 32'h0000_0bad);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("rf_rd", 32'(rf_rd), 32'(e[36:32]));
          chk("rf_wdata", rf_wdata, e[31:0]);
        end
      end else if (exp_q.size() != 0) begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("missing_we", 32'(rf_we), 32'd1);
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_err = 0;
    m_alu_won_last = 0;
    exp_q.delete();
  endtask

  // Evaluate one cycle with the currently driven inputs, then advance to the next drive point.
  task automatic tick();
    bit alu_wins;
    #1;
    alu_wins = alu_valid && (!ld_valid || !m_alu_won_last);
    m_alu_x  = alu_wins;
    m_ld_x   = ld_valid && !alu_wins;
    chk("alu_ready", 32'(alu_ready), 32'(m_alu_x));
    chk("ld_ready", 32'(ld_ready), 32'(m_ld_x));
    chk("rs1_busy", 32'(rs1_busy), 32'(rs1 != 0 && m_pend[rs1]));
    chk("rs2_busy", 32'(rs2_busy), 32'(rs2 != 0 && m_pend[rs2]));
    chk("err_unexpected", 32'(err_unexpected), 32'(m_err));
    if (m_alu_x) begin
      m_alu_won_last = 1;
      if (alu_rd != 0) exp_q.push_back({alu_rd, alu_data});
    end
    if (m_ld_x) begin
      m_alu_won_last = 0;
      if (ld_rd != 0) begin
        exp_q.push_back({ld_rd, ld_data});
        if (!m_pend[ld_rd]) m_err = 1;
      end
      m_pend[ld_rd] = 0;
    end
    if (ld_issue && ld_issue_rd != 0) m_pend[ld_issue_rd] = 1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0; ld_issue = 0;
  endtask

  initial begin
    model_reset();
    #12;
    @(negedge clk); reset = 0; #1;

    // Reset state then idle
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_rf_rd", 32'(rf_rd), 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    tick();

    // ALU only
    alu_valid = 1; alu_rd = 3; alu_data = 32'hDEADBEEF;
    tick();
    idle(); tick(); tick();

    // Contention with loads pre-issued to x7, x8
    ld_issue = 1; ld_issue_rd = 7; tick();
    ld_issue_rd = 8; tick();
    ld_issue = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1111;
    ld_valid = 1; ld_rd = 7; ld_data = 32'h7777;
    tick();
    alu_rd = 2; alu_data = 32'h2222;
    tick();
    ld_rd = 8; ld_data = 32'h8888;
    tick();
    alu_valid = 0;
    tick();
    idle(); tick();

    // Scoreboard set/clear and same-cycle set-wins
    ld_issue = 1; ld_issue_rd = 9; rs1 = 9; rs2 = 9; tick();
    ld_issue = 0; tick();
    ld_valid = 1; ld_rd = 9; ld_data = 32'h9999; tick();
    ld_valid = 0; tick();
    ld_issue = 1; ld_issue_rd = 9; tick();
    ld_valid = 1; ld_rd = 9; ld_data = 32'h9090; tick();
    idle(); tick();
    ld_valid = 1; ld_data = 32'h0909; tick();
    idle(); tick();

    // x0 handling
    alu_valid = 1; alu_rd = 0; alu_data = 32'h5555; tick();
    alu_valid = 0; ld_issue = 1; ld_issue_rd = 0; rs1 = 0; rs2 = 0; tick();
    ld_issue = 0; tick();

    // Unexpected load writeback, sticky error
    ld_valid = 1; ld_rd = 12; ld_data = 32'hC0C0; tick();
    idle(); tick(); tick();

    // Reset mid-stream with x5 pending and a write on the port
    ld_issue = 1; ld_issue_rd = 5; alu_valid = 1; alu_rd = 4; alu_data = 32'h4444; tick();
    chk("pre_rst_we", 32'(rf_we), 1);
    ld_issue = 0; alu_valid = 1; ld_valid = 1; ld_rd = 5; rs1 = 5;
    reset = 1; #1;
    chk("mid_rst_we", 32'(rf_we), 0);
    chk("mid_rst_err", 32'(err_unexpected), 0);
    chk("mid_rst_busy", 32'(rs1_busy), 0);
    chk("mid_rst_alu_ready", 32'(alu_ready), 0);
    chk("mid_rst_ld_ready", 32'(ld_ready), 0);
    model_reset();
    idle();
    @(negedge clk); reset = 0; #1;
    tick();

    // Randomized traffic honouring the hold-until-accepted rule
    for (int c = 0; c < 3000; c++) begin
      if (!alu_valid || m_alu_x) begin
        alu_valid = ($urandom_range(0, 2) != 0);
        alu_rd    = 5'($urandom);
        alu_data  = $urandom;
      end
      if (!ld_valid || m_ld_x) begin
        logic [4:0] r;
        r = 5'($urandom);
        ld_valid = (m_pend[r] && $urandom_range(0, 1) == 1) || ($urandom_range(0, 31) == 0);
        ld_rd    = r;
        ld_data  = $urandom;
      end
      ld_issue    = ($urandom_range(0, 2) == 0);
      ld_issue_rd = 5'($urandom);
      rs1 = 5'($urandom);
      rs2 = 5'($urandom);
      tick();
    end
    idle(); tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
